prog_sequencer: RTL

Run controller for the processor's program counter: accepts a start request with a program select, loads the PC with that program's base address, enables PC advance while the program runs, and stops on a halt instruction or a cycle-budget timeout. Sits between the test harness / top-level start logic and the program counter, replacing direct Start/Reset control of the PC with a sequenced IDLE → LOAD → RUN → DONE flow. Also provides a per-run cycle count for performance reporting.

---
 rtl/prog_sequencer_pkg.sv | 30 +++
 rtl/prog_sequencer_if.sv | 32 +++
 rtl/prog_sequencer_cycle_counter.sv | 39 +++
 rtl/prog_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared constants for the program sequencer: run states, program table and default budget.
// PROG_BASE holds each selectable program's entry address in instruction memory.
package prog_seq_pkg;

  localparam int unsigned PROG_AW = 10;
  localparam int unsigned NPROG = 3;
  localparam logic [15:0] DEFAULT_TIMEOUT = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [PROG_AW-1:0] PROG_BASE [NPROG] = '{10'h000, 10'h100, 10'h200};

  // Unlisted selects fall back to address zero; the sequencer never loads them anyway.
  function automatic logic [PROG_AW-1:0] progBase(input logic [1:0] sel);
    logic [PROG_AW-1:0] base;
    base = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (sel == 2'(i)) begin
        base = PROG_BASE[i];
      end
    end
    return base;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Start/stop handshake and PC-control bundle between the harness and the sequencer.
// master = harness / decoder side, slave = the sequencer itself.
interface prog_sequencer_if #(
  parameter int unsigned L  = 10,
  parameter int unsigned TW = 16
);

  logic          Start;
  logic [1:0]    ProgSel;
  logic          Abort;
  logic          Halt;
  logic          Ack;
  logic          Err;
  logic          Busy;
  logic          Done;
  logic          Timeout;
  logic          PcLoad;
  logic [L-1:0]  PcLoadAddr;
  logic          PcEn;
  logic [TW-1:0] CycleCount;

  modport master (
    output Start, ProgSel, Abort, Halt,
    input  Ack, Err, Busy, Done, Timeout, PcLoad, PcLoadAddr, PcEn, CycleCount
  );

  modport slave (
    input  Start, ProgSel, Abort, Halt,
    output Ack, Err, Busy, Done, Timeout, PcLoad, PcLoadAddr, PcEn, CycleCount
  );

endinterface

// File: rtl/prog_sequencer_cycle_counter.sv
// Per-run cycle counter with synchronous clear and a terminal-count flag one short of the budget.
module cycle_counter #(
  parameter int unsigned   TW      = 16,
  parameter logic [TW-1:0] TIMEOUT = 16'hFFF0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [TW-1:0] count_o,
  output logic          tc_o
);

  localparam logic [TW-1:0] TC_VALUE = TIMEOUT - TW'(1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TC_VALUE);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller for the program counter: IDLE -> LOAD -> RUN -> DONE with halt/budget stop,
// abort, and a per-run cycle count. Every output is registered except PcEn.
module prog_sequencer #(
  parameter int unsigned   L       = 10,
  parameter int unsigned   NPROG   = prog_seq_pkg::NPROG,
  parameter int unsigned   TW      = 16,
  parameter logic [TW-1:0] TIMEOUT = TW'(prog_seq_pkg::DEFAULT_TIMEOUT)
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_sequencer_if.slave bus_io
);

  import prog_seq_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state_q,   state_d;
  logic [1:0]    sel_q,     sel_d;
  logic          ack_q,     ack_d;
  logic          err_q,     err_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          timeout_q, timeout_d;
  logic          pcLoad_q,  pcLoad_d;
  logic [L-1:0]  pcAddr_q,  pcAddr_d;

  logic          progValid;
  logic          startOk;
  logic          startBad;
  logic          accept;
  logic          cntEn;
  logic          cntTc;
  logic [TW-1:0] cntValue;

  assign progValid = 32'(bus_io.ProgSel) < NPROG;
  assign startOk   = bus_io.Start && progValid;
  assign startBad  = bus_io.Start && !progValid;

  // Abort outranks everything; only IDLE and DONE listen to Start.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;
    accept    = 1'b0;
    err_d     = 1'b0;
    if (bus_io.Abort) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (startOk) begin
            accept    = 1'b1;
            state_d   = ST_LOAD;
            sel_d     = bus_io.ProgSel;
            timeout_d = 1'b0;
          end else if (startBad) begin
            err_d = 1'b1;
          end
        end
        ST_LOAD: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus_io.Halt) begin
            state_d   = ST_DONE;
            timeout_d = 1'b0;
          end else if (cntTc) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ack_d    = accept;
    pcLoad_d = accept;
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);
    pcAddr_d = accept ? L'(progBase(sel_d)) : pcAddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      pcLoad_q  <= 1'b0;
      pcAddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      pcLoad_q  <= pcLoad_d;
      pcAddr_q  <= pcAddr_d;
    end
  end

  // The abort cycle does not count, so an aborted run reports the cycles it completed.
  assign cntEn = (state_q == ST_RUN) && !bus_io.Abort;

  cycle_counter #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .en_i    (cntEn),
    .count_o (cntValue),
    .tc_o    (cntTc)
  );

  assign bus_io.Ack        = ack_q;
  assign bus_io.Err        = err_q;
  assign bus_io.Busy       = busy_q;
  assign bus_io.Done       = done_q;
  assign bus_io.Timeout    = timeout_q;
  assign bus_io.PcLoad     = pcLoad_q;
  assign bus_io.PcLoadAddr = pcAddr_q;
  assign bus_io.CycleCount = cntValue;
  assign bus_io.PcEn       = (state_q == ST_RUN) && !bus_io.Halt;

endmodule
